// File: rtl/flag_branch_sequencer.sv
// flag_branch_sequencer: owns the program counter, accepts one decoded
// instruction per valid/ready handshake and resolves jumps against the
// registered carry/zero flags. After every flag-writing ALU op it stalls
// for FLAG_LAT cycles so that c/z are current before a conditional jump.
module flag_branch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                FLAG_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic              c,
    input  logic              z,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              halted
);

    // Stall counter only has to hold FLAG_LAT-1; keep at least one bit.
    localparam int               CNT_W      = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
    localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(FLAG_LAT - 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JC   = 3'b010;
    localparam logic [2:0] OP_JZ   = 3'b011;
    localparam logic [2:0] OP_JNC  = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLAG_WAIT,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              taken_nxt;
    logic [CNT_W-1:0]  stall_cnt, cnt_nxt;
    logic              accept;

    // Branch condition for the four conditional jumps; other ops never take.
    function automatic logic cond_met(input logic [2:0] opc, input logic cf, input logic zf);
        logic res;
        res = 1'b0;
        case (opc)
            OP_JC:   res = cf;
            OP_JZ:   res = zf;
            OP_JNC:  res = ~cf;
            OP_JNZ:  res = ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Ready is forced low while reset is asserted, independent of state.
    assign instr_ready = (state == S_RUN) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign halted      = (state == S_HALT);

    // State register, program counter, jump pulse and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            pc        <= RESET_PC;
            taken     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            taken     <= taken_nxt;
            stall_cnt <= cnt_nxt;
        end
    end

    // Next-state decode: instruction effects on accept, stall countdown, halt.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        taken_nxt = 1'b0;
        cnt_nxt   = stall_cnt;
        case (state)
            S_RUN: begin
                if (accept) begin
                    case (op)
                        OP_NOP: pc_nxt = pc + ADDR_W'(1);
                        OP_ALU: begin
                            pc_nxt    = pc + ADDR_W'(1);
                            state_nxt = S_FLAG_WAIT;
                            cnt_nxt   = STALL_INIT;
                        end
                        OP_JMP: begin
                            pc_nxt    = target;
                            taken_nxt = 1'b1;
                        end
                        OP_JC, OP_JZ, OP_JNC, OP_JNZ: begin
                            // c/z are looked at only here, in the accept cycle.
                            if (cond_met(op, c, z)) begin
                                pc_nxt    = target;
                                taken_nxt = 1'b1;
                            end else begin
                                pc_nxt = pc + ADDR_W'(1);
                            end
                        end
                        OP_HALT: state_nxt = S_HALT;
                        default: pc_nxt = pc;
                    endcase
                end
            end
            S_FLAG_WAIT: begin
                if (stall_cnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = stall_cnt - CNT_W'(1);
                end
            end
            S_HALT: begin
                // Frozen until reset.
                state_nxt = S_HALT;
            end
            default: state_nxt = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_flag_branch_sequencer.sv
// Directed bench for flag_branch_sequencer (RESET_PC=0x10, FLAG_LAT=2).
module tb_flag_branch_sequencer;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic              c;
    logic              z;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              halted;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] JC   = 3'b010;
    localparam logic [2:0] JZ   = 3'b011;
    localparam logic [2:0] JNC  = 3'b100;
    localparam logic [2:0] JNZ  = 3'b101;
    localparam logic [2:0] ALU  = 3'b110;
    localparam logic [2:0] HALT = 3'b111;

    flag_branch_sequencer #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(8'h10),
        .FLAG_LAT(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .op         (op),
        .target     (target),
        .c          (c),
        .z          (z),
        .pc         (pc),
        .taken      (taken),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (observed=running required=finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Present one input vector from the falling edge, return 1ns after the next rising edge.
    task automatic cyc(input logic v, input logic [2:0] o, input logic [7:0] t,
                       input logic cc, input logic zz);
        @(negedge clk);
        instr_valid = v;
        op          = o;
        target      = t;
        c           = cc;
        z           = zz;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] cond_ops [4];
    logic [7:0] exp_pc;

    initial begin
        cond_ops[0] = JC;
        cond_ops[1] = JZ;
        cond_ops[2] = JNC;
        cond_ops[3] = JNZ;
        rst = 1'b0; instr_valid = 1'b0; op = NOP; target = '0; c = 1'b0; z = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_pc", 32'(pc), 32'h10);
        chk("rst_taken", 32'(taken), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_ready", 32'(instr_ready), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", 32'(instr_ready), 1);

        // Three back-to-back NOPs
        cyc(1, NOP, 8'h00, 0, 0); chk("nop1_pc", 32'(pc), 32'h11); chk("nop1_taken", 32'(taken), 0);
        cyc(1, NOP, 8'h00, 0, 0); chk("nop2_pc", 32'(pc), 32'h12); chk("nop2_taken", 32'(taken), 0);
        cyc(1, NOP, 8'h00, 0, 0); chk("nop3_pc", 32'(pc), 32'h13); chk("nop3_taken", 32'(taken), 0);

        // Wrap and unconditional jump
        cyc(1, JMP, 8'hFF, 0, 0); chk("jmpff_pc", 32'(pc), 32'hFF); chk("jmpff_taken", 32'(taken), 1);
        cyc(1, NOP, 8'h00, 0, 0); chk("wrap_pc", 32'(pc), 32'h00); chk("wrap_taken", 32'(taken), 0);
        cyc(1, JMP, 8'h40, 0, 0); chk("jmp40_pc", 32'(pc), 32'h40); chk("jmp40_taken", 32'(taken), 1);
        cyc(0, JMP, 8'h77, 0, 0); chk("idle_pc", 32'(pc), 32'h40); chk("idle_taken", 32'(taken), 0);

        // ALU stall then JZ taken (z=1)
        cyc(1, ALU, 8'h00, 0, 0); chk("alu1_pc", 32'(pc), 32'h41); chk("alu1_ready", 32'(instr_ready), 0);
        cyc(1, JZ, 8'h20, 0, 1);  chk("st1_ready", 32'(instr_ready), 0); chk("st1_pc", 32'(pc), 32'h41);
        cyc(1, JZ, 8'h20, 0, 1);  chk("st2_ready", 32'(instr_ready), 1); chk("st2_pc", 32'(pc), 32'h41);
        chk("st2_taken", 32'(taken), 0);
        cyc(1, JZ, 8'h20, 0, 1);  chk("jz1_pc", 32'(pc), 32'h20); chk("jz1_taken", 32'(taken), 1);

        // ALU stall then JZ not taken (z=0)
        cyc(1, ALU, 8'h00, 0, 1); chk("alu2_pc", 32'(pc), 32'h21); chk("alu2_taken", 32'(taken), 0);
        cyc(1, JZ, 8'h90, 0, 0);  chk("st3_ready", 32'(instr_ready), 0);
        cyc(1, JZ, 8'h90, 0, 0);  chk("st4_pc", 32'(pc), 32'h21);
        cyc(1, JZ, 8'h90, 0, 0);  chk("jz0_pc", 32'(pc), 32'h22); chk("jz0_taken", 32'(taken), 0);

        // Conditional jump matrix
        exp_pc = 8'h22;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 4; b++) begin
                logic [2:0] o;
                logic       cc, zz, exp_t;
                logic [7:0] tgt;
                o   = cond_ops[k];
                cc  = b[0];
                zz  = b[1];
                tgt = exp_pc + 8'h37;
                case (o)
                    JC:      exp_t = cc;
                    JZ:      exp_t = zz;
                    JNC:     exp_t = ~cc;
                    default: exp_t = ~zz;
                endcase
                cyc(1, o, tgt, cc, zz);
                exp_pc = exp_t ? tgt : exp_pc + 8'h01;
                chk($sformatf("cond_op%0d_c%0d_z%0d_pc", o, cc, zz), 32'(pc), 32'(exp_pc));
                chk($sformatf("cond_op%0d_c%0d_z%0d_taken", o, cc, zz), 32'(taken), 32'(exp_t));
            end
        end

        // Jump to own pc
        cyc(1, JMP, exp_pc, 0, 0); chk("self_pc", 32'(pc), 32'(exp_pc)); chk("self_taken", 32'(taken), 1);

        // HALT freezes everything
        cyc(1, HALT, 8'h00, 0, 0);
        chk("halt_pc", 32'(pc), 32'(exp_pc));
        chk("halt_halted", 32'(halted), 1);
        chk("halt_ready", 32'(instr_ready), 0);
        chk("halt_taken", 32'(taken), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, JMP, 8'h55, 1, 1);
            chk($sformatf("halt_hold%0d_pc", i), 32'(pc), 32'(exp_pc));
            chk($sformatf("halt_hold%0d_halted", i), 32'(halted), 1);
            chk($sformatf("halt_hold%0d_ready", i), 32'(instr_ready), 0);
        end

        // Asynchronous reset from HALT
        #2 rst = 1'b1;
        #1;
        chk("rsth_pc", 32'(pc), 32'h10);
        chk("rsth_halted", 32'(halted), 0);
        chk("rsth_taken", 32'(taken), 0);
        chk("rsth_ready", 32'(instr_ready), 0);
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;
        #1 chk("rsth_rel_ready", 32'(instr_ready), 1);
        cyc(1, NOP, 8'h00, 0, 0); chk("rsth_nop_pc", 32'(pc), 32'h11);

        // Asynchronous reset during the flag stall
        cyc(1, ALU, 8'h00, 0, 0); chk("alu3_pc", 32'(pc), 32'h12); chk("alu3_ready", 32'(instr_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("rstw_pc", 32'(pc), 32'h10);
        chk("rstw_taken", 32'(taken), 0);
        chk("rstw_halted", 32'(halted), 0);
        @(negedge clk);
        rst = 1'b0; instr_valid = 1'b0;
        #1 chk("rstw_rel_ready", 32'(instr_ready), 1);
        cyc(1, JMP, 8'h33, 0, 0); chk("rstw_jmp_pc", 32'(pc), 32'h33); chk("rstw_jmp_taken", 32'(taken), 1);
        cyc(0, NOP, 8'h00, 0, 0); chk("final_taken", 32'(taken), 0); chk("final_pc", 32'(pc), 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
